// File: rtl/market_msg_parser_mc.sv
`default_nettype none
// ============================================================================
// Module      : market_msg_parser_mc
// Description : Streaming multi-beat market-data parser with length framing,
//               per-channel sequence-gap detection, malformed drop and stats.
// Revision    : 1.0 - initial release
// ============================================================================
module market_msg_parser_mc #(
   parameter int DATA_WIDTH     = 64,
   parameter int SYMBOL_WIDTH   = 32,
   parameter int PRICE_WIDTH    = 32,
   parameter int QUANTITY_WIDTH = 32,
   parameter int NUM_CHANNELS   = 4,
   parameter int SEQ_WIDTH      = 32,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [DATA_WIDTH-1:0]     in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [1:0]                out_msg_type,
   output logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] out_channel,
   output logic [SEQ_WIDTH-1:0]      out_seq,
   output logic [SYMBOL_WIDTH-1:0]   out_symbol,
   output logic [PRICE_WIDTH-1:0]    out_price,
   output logic [QUANTITY_WIDTH-1:0] out_quantity,
   output logic                      out_seq_gap,
   output logic [CNT_WIDTH-1:0]      msg_count,
   output logic [CNT_WIDTH-1:0]      drop_count,
   output logic [CNT_WIDTH-1:0]      gap_count
);

   localparam int c_ch_w = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
   localparam logic [SEQ_WIDTH-1:0] c_seq_one = SEQ_WIDTH'(1);

   typedef enum logic [2:0] {
      ST_HDR  = 3'd0,
      ST_SYM  = 3'd1,
      ST_PRC  = 3'd2,
      ST_QTY  = 3'd3,
      ST_SKIP = 3'd4,
      ST_DROP = 3'd5,
      ST_OUT  = 3'd6
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [7:0]            r_len;
   logic [7:0]            r_remain;
   logic                  r_seen    [NUM_CHANNELS];
   logic [SEQ_WIDTH-1:0]  r_exp_seq [NUM_CHANNELS];

   logic                  w_in_fire;
   logic                  w_out_fire;
   logic                  w_hdr_fire;
   logic                  w_malformed;
   logic                  w_gap;
   logic [1:0]            w_hdr_type;
   logic [7:0]            w_hdr_len;
   logic [c_ch_w-1:0]     w_hdr_ch;
   logic [SEQ_WIDTH-1:0]  w_hdr_seq;
   logic                  w_unused_bits;

   assign w_hdr_type = in_data[1:0];
   assign w_hdr_len  = in_data[15:8];
   assign w_hdr_seq  = in_data[32 +: SEQ_WIDTH];

   // With a single channel there are no channel bits to decode.
   generate
      if (NUM_CHANNELS > 1) begin : g_multi_ch
         assign w_hdr_ch = in_data[16 +: c_ch_w];
      end else begin : g_single_ch
         assign w_hdr_ch = '0;
      end
   endgenerate

   assign w_unused_bits = ^in_data;

   assign in_ready    = (r_state != ST_OUT);
   assign out_valid   = (r_state == ST_OUT);
   assign w_in_fire   = in_valid && in_ready;
   assign w_out_fire  = out_valid && out_ready;
   assign w_hdr_fire  = w_in_fire && (r_state == ST_HDR);
   assign w_malformed = (w_hdr_type == 2'b00) || (w_hdr_len < 8'd3);
   assign w_gap       = r_seen[w_hdr_ch] && (w_hdr_seq != r_exp_seq[w_hdr_ch]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_HDR;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_HDR: begin
            if (w_in_fire) begin
               if (w_malformed) begin
                  w_next = (w_hdr_len == 8'd0) ? ST_HDR : ST_DROP;
               end else begin
                  w_next = ST_SYM;
               end
            end
         end
         ST_SYM:  if (w_in_fire) w_next = ST_PRC;
         ST_PRC:  if (w_in_fire) w_next = ST_QTY;
         ST_QTY:  if (w_in_fire) w_next = (r_len > 8'd3) ? ST_SKIP : ST_OUT;
         ST_SKIP: if (w_in_fire && (r_remain == 8'd1)) w_next = ST_OUT;
         ST_DROP: if (w_in_fire && (r_remain == 8'd1)) w_next = ST_HDR;
         ST_OUT:  if (w_out_fire) w_next = ST_HDR;
         default: w_next = ST_HDR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len        <= '0;
         r_remain     <= '0;
         out_msg_type <= '0;
         out_channel  <= '0;
         out_seq      <= '0;
         out_symbol   <= '0;
         out_price    <= '0;
         out_quantity <= '0;
         out_seq_gap  <= 1'b0;
         msg_count    <= '0;
         drop_count   <= '0;
         gap_count    <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            r_seen[i]    <= 1'b0;
            r_exp_seq[i] <= '0;
         end
      end else begin
         if (w_hdr_fire) begin
            r_len <= w_hdr_len;
            if (w_malformed) begin
               r_remain   <= w_hdr_len;
               drop_count <= drop_count + c_cnt_one;
            end else begin
               out_msg_type          <= w_hdr_type;
               out_channel           <= w_hdr_ch;
               out_seq               <= w_hdr_seq;
               out_seq_gap           <= w_gap;
               r_seen[w_hdr_ch]      <= 1'b1;
               r_exp_seq[w_hdr_ch]   <= w_hdr_seq + c_seq_one;
               if (w_gap) begin
                  gap_count <= gap_count + c_cnt_one;
               end
            end
         end
         // Payload fields are captured directly into the held output registers.
         if (w_in_fire) begin
            case (r_state)
               ST_SYM:  out_symbol <= in_data[SYMBOL_WIDTH-1:0];
               ST_PRC:  out_price  <= in_data[PRICE_WIDTH-1:0];
               ST_QTY: begin
                  out_quantity <= in_data[QUANTITY_WIDTH-1:0];
                  r_remain     <= r_len - 8'd3;
               end
               ST_SKIP, ST_DROP: r_remain <= r_remain - 8'd1;
               default: ;
            endcase
         end
         if (w_out_fire) begin
            msg_count <= msg_count + c_cnt_one;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_market_msg_parser_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_market_msg_parser_mc
// Description : Directed table-driven bench for market_msg_parser_mc.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_market_msg_parser_mc;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [63:0] in_data;
   logic        in_ready;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_msg_type;
   logic [1:0]  out_channel;
   logic [31:0] out_seq;
   logic [31:0] out_symbol;
   logic [31:0] out_price;
   logic [31:0] out_quantity;
   logic        out_seq_gap;
   logic [15:0] msg_count;
   logic [15:0] drop_count;
   logic [15:0] gap_count;

   int n_cmp;
   int n_fail;

   market_msg_parser_mc dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_msg_type (out_msg_type),
      .out_channel  (out_channel),
      .out_seq      (out_seq),
      .out_symbol   (out_symbol),
      .out_price    (out_price),
      .out_quantity (out_quantity),
      .out_seq_gap  (out_seq_gap),
      .msg_count    (msg_count),
      .drop_count   (drop_count),
      .gap_count    (gap_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  mtype;
      logic [7:0]  len;
      logic [7:0]  ch;
      logic [31:0] seq;
      logic [31:0] sym;
      logic [31:0] price;
      logic [31:0] qty;
      logic        exp_out;
      logic [1:0]  exp_ch;
      logic        exp_gap;
      logic [15:0] exp_msg;
      logic [15:0] exp_drop;
      logic [15:0] exp_gapc;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_beat(input logic [63:0] d);
      int waited;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         n_cmp++;
         n_fail++;
         $display("FAIL beat_accept: in_ready stuck at 0, expected 1");
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   function automatic logic [63:0] hdr_word(input logic [1:0] t, input logic [7:0] len,
                                            input logic [7:0] ch, input logic [31:0] seq);
      return {seq, 8'hA5, ch, len, 6'h2A, t};
   endfunction

   task automatic send_payload(input vec_t v, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         if (i == 1)      send_beat({32'hCAFE0001, v.sym});
         else if (i == 2) send_beat({32'hCAFE0002, v.price});
         else if (i == 3) send_beat({32'hCAFE0003, v.qty});
         else             send_beat({32'hBEEF0000 | i, 32'h0BAD0000 | i});
      end
   endtask

   task automatic check_out(input string tag, input vec_t v);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_type"}, out_msg_type, v.mtype);
      check({tag, "_ch"}, out_channel, v.exp_ch);
      check({tag, "_seq"}, out_seq, v.seq);
      check({tag, "_sym"}, out_symbol, v.sym);
      check({tag, "_price"}, out_price, v.price);
      check({tag, "_qty"}, out_quantity, v.qty);
      check({tag, "_gap"}, out_seq_gap, v.exp_gap);
   endtask

   task automatic check_counts(input string tag, input logic [15:0] m,
                               input logic [15:0] d, input logic [15:0] g);
      check({tag, "_msg_count"}, msg_count, m);
      check({tag, "_drop_count"}, drop_count, d);
      check({tag, "_gap_count"}, gap_count, g);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_fields"}, {out_msg_type, out_channel, out_seq_gap}, 0);
      check({tag, "_seq"}, out_seq, 0);
      check({tag, "_sym"}, out_symbol, 0);
      check({tag, "_price"}, out_price, 0);
      check({tag, "_qty"}, out_quantity, 0);
      check_counts(tag, 16'd0, 16'd0, 16'd0);
   endtask

   initial begin
      vec_t        v;
      logic [132:0] snap;
      n_cmp     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      //        type   len   ch     seq           sym           price      qty       out   ch    gap   msg     drop   gapc
      vecs[0]  = '{2'b01, 8'd3, 8'h02, 32'd5,        32'h41414141, 32'd100,  32'd7,    1'b1, 2'd2, 1'b0, 16'd1,  16'd0, 16'd0};
      vecs[1]  = '{2'b10, 8'd6, 8'h03, 32'd20,       32'h51554F54, 32'd2000, 32'd300,  1'b1, 2'd3, 1'b0, 16'd2,  16'd0, 16'd0};
      vecs[2]  = '{2'b00, 8'd4, 8'h00, 32'd99,       32'h00000001, 32'd2,    32'd3,    1'b0, 2'd0, 1'b0, 16'd2,  16'd1, 16'd0};
      vecs[3]  = '{2'b01, 8'd3, 8'h02, 32'd6,        32'h41424344, 32'd101,  32'd8,    1'b1, 2'd2, 1'b0, 16'd3,  16'd1, 16'd0};
      vecs[4]  = '{2'b11, 8'd3, 8'h01, 32'd10,       32'h4F524452, 32'd55,   32'd9,    1'b1, 2'd1, 1'b0, 16'd4,  16'd1, 16'd0};
      vecs[5]  = '{2'b01, 8'd3, 8'h01, 32'd12,       32'h54524431, 32'd56,   32'd10,   1'b1, 2'd1, 1'b1, 16'd5,  16'd1, 16'd1};
      vecs[6]  = '{2'b10, 8'd3, 8'h00, 32'hFFFFFFFF, 32'h57524150, 32'd1,    32'd1,    1'b1, 2'd0, 1'b0, 16'd6,  16'd1, 16'd1};
      vecs[7]  = '{2'b01, 8'd4, 8'h00, 32'd0,        32'h57524151, 32'd2,    32'd2,    1'b1, 2'd0, 1'b0, 16'd7,  16'd1, 16'd1};
      vecs[8]  = '{2'b01, 8'd2, 8'h01, 32'd13,       32'h12345678, 32'd3,    32'd3,    1'b0, 2'd0, 1'b0, 16'd7,  16'd2, 16'd1};
      vecs[9]  = '{2'b11, 8'd3, 8'h01, 32'd13,       32'h4F524453, 32'd77,   32'd4,    1'b1, 2'd1, 1'b0, 16'd8,  16'd2, 16'd1};
      vecs[10] = '{2'b01, 8'd0, 8'h02, 32'd50,       32'h0,        32'd0,    32'd0,    1'b0, 2'd0, 1'b0, 16'd8,  16'd3, 16'd1};
      vecs[11] = '{2'b01, 8'd3, 8'hF6, 32'd7,        32'h484C5431, 32'd900,  32'd12,   1'b1, 2'd2, 1'b0, 16'd9,  16'd3, 16'd1};
      vecs[12] = '{2'b10, 8'd5, 8'h03, 32'd22,       32'h51554F55, 32'd2001, 32'd301,  1'b1, 2'd3, 1'b1, 16'd10, 16'd3, 16'd2};

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 13; k++) begin
         v = vecs[k];
         send_beat(hdr_word(v.mtype, v.len, v.ch, v.seq));
         send_payload(v, 1, int'(v.len));
         if (v.exp_out) begin
            check_out($sformatf("v%0d", k), v);
            @(negedge clk);
            check($sformatf("v%0d_pop", k), out_valid, 1'b0);
         end else begin
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_no_out", k), out_valid, 1'b0);
         end
         check_counts($sformatf("v%0d", k), v.exp_msg, v.exp_drop, v.exp_gapc);
      end

      // Output backpressure: message held while the next header waits.
      out_ready = 1'b0;
      v = '{2'b01, 8'd3, 8'h02, 32'd8, 32'h42504B31, 32'd333, 32'd44, 1'b1, 2'd2, 1'b0, 16'd11, 16'd3, 16'd2};
      send_beat(hdr_word(v.mtype, v.len, v.ch, v.seq));
      send_payload(v, 1, 3);
      check_out("bp_hold", v);
      snap = {out_msg_type, out_channel, out_seq, out_symbol, out_price, out_quantity, out_seq_gap};
      in_valid = 1'b1;
      in_data  = hdr_word(2'b01, 8'd3, 8'h02, 32'd9);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || msg_count !== 16'd10 ||
             {out_msg_type, out_channel, out_seq, out_symbol, out_price, out_quantity, out_seq_gap} !== snap) begin
            n_fail++;
            $display("FAIL bp_stable cycle %0d: in_ready=%b out_valid=%b msg_count=%0d, expected 0/1/10 with outputs held",
                     c, in_ready, out_valid, msg_count);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", out_valid, 1'b0);
      check("bp_release_ready", in_ready, 1'b1);
      check("bp_release_msg_count", msg_count, 16'd11);
      send_beat(hdr_word(2'b01, 8'd3, 8'h02, 32'd9));
      v = '{2'b01, 8'd3, 8'h02, 32'd9, 32'h42504B32, 32'd334, 32'd45, 1'b1, 2'd2, 1'b0, 16'd12, 16'd3, 16'd2};
      send_payload(v, 1, 3);
      check_out("bp_next", v);
      @(negedge clk);
      check_counts("bp_next", 16'd12, 16'd3, 16'd2);

      // Reset mid-message, after the price beat.
      v = '{2'b01, 8'd3, 8'h01, 32'd100, 32'h52535431, 32'd500, 32'd60, 1'b1, 2'd1, 1'b0, 16'd1, 16'd0, 16'd0};
      send_beat(hdr_word(v.mtype, v.len, v.ch, v.seq));
      send_payload(v, 1, 2);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send_beat(hdr_word(v.mtype, v.len, v.ch, v.seq));
      send_payload(v, 1, 3);
      check_out("post_reset", v);
      @(negedge clk);
      check_counts("post_reset", 16'd1, 16'd0, 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
